// File: rtl/typewriter_pkg.sv
// Shared types and constants for the typewriter text row.
// CURSOR_BLINK_EN selects the blinking cursor build.
package typewriter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TYPING,
        DONE
    } state_t;

    localparam logic [7:0] CURSOR_CHAR = 8'h5F;
    localparam int CURSOR_HALF_PERIOD = 16;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by DELAY_CYCLES while enabled; tick is high
// for the one cycle in which the counter wraps.
module tick_prescaler
    import typewriter_pkg::*;
#(
    parameter int DELAY_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    // one extra bit keeps the width >=1 when DELAY_CYCLES is 1
    localparam int CW = clog2(DELAY_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DELAY_CYCLES - 1);

    logic [CW-1:0] count;

    assign tick = en && !clear && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/typewriter_text_row.sv
// Text row with typewriter reveal between command source and
// font renderer. Define CURSOR_BLINK_EN for a blinking cursor.
module typewriter_text_row
    import typewriter_pkg::*;
#(
    parameter int ROW_LEN = 16,
    parameter logic [7:0] ADDRESS_OFFSET = 8'd0,
    parameter int DELAY_CYCLES = 50000,
    localparam int IDX_W = clog2(ROW_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W:0]   msg_len,
    input  logic             start,
    input  logic             pause,
    input  logic [7:0]       readAddress,
    output logic [7:0]       outByte,
    output logic [IDX_W:0]   revealed,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W:0] ROW_LEN_C = (IDX_W + 1)'(ROW_LEN);

    state_t state;
    state_t state_next;

    logic [IDX_W:0] len_q;
    logic [IDX_W:0] len_next;
    logic [IDX_W:0] revealed_next;
    logic [IDX_W:0] start_len;
    logic           done_next;
    logic           tick;

    logic [7:0]       buffer [ROW_LEN];
    logic [8:0]       diff;
    logic [7:0]       idx;
    logic [IDX_W-1:0] idx_lo;
    logic             addr_ok;
    logic             visible;

    assign busy = (state == TYPING);
    assign start_len = (msg_len > ROW_LEN_C) ? ROW_LEN_C : msg_len;

    tick_prescaler #(
        .DELAY_CYCLES(DELAY_CYCLES)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (busy && !pause),
        .clear(start),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        len_next      = len_q;
        revealed_next = revealed;
        done_next     = 1'b0;
        if (start) begin
            len_next      = start_len;
            revealed_next = '0;
            if (start_len == '0) begin
                state_next = DONE;
                done_next  = 1'b1;
            end else begin
                state_next = TYPING;
            end
        end else if (tick) begin
            revealed_next = revealed + (IDX_W + 1)'(1);
            if (revealed_next == len_q) begin
                state_next = DONE;
                done_next  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            revealed <= '0;
            done     <= 1'b0;
        end else begin
            len_q    <= len_next;
            revealed <= revealed_next;
            done     <= done_next;
        end
    end

    // text storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < ROW_LEN_C)) begin
            buffer[wr_addr] <= wr_data;
        end
    end

    // borrow bit tells whether readAddress is below the offset
    assign diff    = {1'b0, readAddress} - {1'b0, ADDRESS_OFFSET};
    assign addr_ok = !diff[8];
    assign idx     = diff[7:0];
    assign idx_lo  = idx[IDX_W-1:0];
    assign visible = addr_ok && (32'(idx) < 32'(revealed));

`ifdef CURSOR_BLINK_EN
    localparam int BW = clog2(CURSOR_HALF_PERIOD + 1);
    localparam logic [BW-1:0] BLINK_LAST =
        BW'(CURSOR_HALF_PERIOD - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic          cursor_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (start) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= !blink_on;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign cursor_hit = blink_on && (state != IDLE) && addr_ok &&
                        (32'(idx) == 32'(revealed)) &&
                        (32'(idx) < 32'(ROW_LEN));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outByte <= 8'h00;
        end else if (visible) begin
            outByte <= buffer[idx_lo];
`ifdef CURSOR_BLINK_EN
        end else if (cursor_hit) begin
            outByte <= CURSOR_CHAR;
`endif
        end else begin
            outByte <= 8'h00;
        end
    end

endmodule
